// File: rtl/sorted_region_checker.sv
// Scans a window of data memory once per start, counting adjacent-order violations and
// expected-ROM mismatches. Define CHECK_EXP_EN to enable the expected-ROM comparison.
module sorted_region_checker #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 7,
    parameter int BASE       = 32,
    parameter int DEPTH      = 96,
    parameter int DESCENDING = 1,
    parameter int SIGNED     = 0,
    parameter int ERR_W      = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_rdata,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_unsorted,
    output logic [ERR_W-1:0]  err_exp,
    output logic [ADDR_W-1:0] first_bad,
    output logic              pass
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [DATA_W-1:0]   prev_q;
    logic [ERR_W-1:0]    errUns_q, errUns_d;
    logic [ERR_W-1:0]    errExp_q, errExp_d;
    logic [ADDR_W-1:0]   firstBad_q;
    logic                badSeen_q;
    logic                pass_q, busy_q, done_q;

    logic prevLt, prevGt, orderViol, expViol;

    // Index wraps to 0 after the last word so the address never leaves the window.
    assign mem_addr = BASE_A + idx_q;

`ifdef CHECK_EXP_EN
    assign exp_addr = idx_q;
    assign expViol  = (mem_rdata != exp_rdata);
`else
    logic unusedExpData;
    assign unusedExpData = ^exp_rdata;
    assign exp_addr      = '0;
    assign expViol       = 1'b0;
`endif

    always_comb begin
        prevLt    = (SIGNED != 0) ? ($signed(prev_q) < $signed(mem_rdata)) : (prev_q < mem_rdata);
        prevGt    = (SIGNED != 0) ? ($signed(prev_q) > $signed(mem_rdata)) : (prev_q > mem_rdata);
        orderViol = (idx_q != '0) && ((DESCENDING != 0) ? prevLt : prevGt);
        errUns_d  = (orderViol && (errUns_q != '1)) ? errUns_q + 1'b1 : errUns_q;
        errExp_d  = (expViol && (errExp_q != '1)) ? errExp_q + 1'b1 : errExp_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            prev_q     <= '0;
            errUns_q   <= '0;
            errExp_q   <= '0;
            firstBad_q <= '1;
            badSeen_q  <= 1'b0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q    <= SCAN;
                        idx_q      <= '0;
                        errUns_q   <= '0;
                        errExp_q   <= '0;
                        firstBad_q <= '1;
                        badSeen_q  <= 1'b0;
                        pass_q     <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SCAN: begin
                    prev_q   <= mem_rdata;
                    errUns_q <= errUns_d;
                    errExp_q <= errExp_d;
                    // A separate flag keeps an all-ones window index distinguishable from "none".
                    if ((orderViol || expViol) && !badSeen_q) begin
                        firstBad_q <= idx_q;
                        badSeen_q  <= 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (errUns_d == '0) && (errExp_d == '0);
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err_unsorted = errUns_q;
    assign err_exp      = errExp_q;
    assign first_bad    = firstBad_q;
    assign pass         = pass_q;

endmodule

// File: tb/tb_sorted_region_checker.sv
// Self-checking bench: four checker instances with different parameters share one memory,
// ROM and start line; results are compared against a pairwise reference model.
module tb_sorted_region_checker;

    localparam int NI = 4;
    localparam int DEPTHS [NI] = '{4, 4, 8, 6};
    localparam int ERRWS  [NI] = '{9, 9, 2, 3};
    localparam int DESCS  [NI] = '{1, 1, 1, 0};
    localparam int SIGNS  [NI] = '{0, 1, 0, 1};
`ifdef CHECK_EXP_EN
    localparam bit EXP_ON = 1'b1;
`else
    localparam bit EXP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:127];
    logic [31:0] rom [0:127];

    logic [6:0]  memAddrV  [NI];
    logic [6:0]  expAddrV  [NI];
    logic [31:0] memRdataV [NI];
    logic [31:0] expRdataV [NI];
    logic        busyV     [NI];
    logic        doneV     [NI];
    logic        passV     [NI];
    logic [8:0]  errUV     [NI];
    logic [8:0]  errEV     [NI];
    logic [6:0]  firstBadV [NI];
    logic [8:0]  errU0, errE0, errU1, errE1;
    logic [1:0]  errU2, errE2;
    logic [2:0]  errU3, errE3;

    int total = 0;
    int bad = 0;
    int addrBad [NI] = '{0, 0, 0, 0};

    for (genvar g = 0; g < NI; g++) begin : g_mem
        assign memRdataV[g] = mem[memAddrV[g]];
        assign expRdataV[g] = rom[expAddrV[g]];
    end
    assign errUV[0] = errU0;
    assign errEV[0] = errE0;
    assign errUV[1] = errU1;
    assign errEV[1] = errE1;
    assign errUV[2] = {7'd0, errU2};
    assign errEV[2] = {7'd0, errE2};
    assign errUV[3] = {6'd0, errU3};
    assign errEV[3] = {6'd0, errE3};

    sorted_region_checker #(.DATA_W(32), .ADDR_W(7), .BASE(32), .DEPTH(4), .DESCENDING(1), .SIGNED(0), .ERR_W(9)) u0 (
        .clk(clk), .reset(reset), .start(start), .mem_addr(memAddrV[0]), .mem_rdata(memRdataV[0]),
        .exp_addr(expAddrV[0]), .exp_rdata(expRdataV[0]), .busy(busyV[0]), .done(doneV[0]),
        .err_unsorted(errU0), .err_exp(errE0), .first_bad(firstBadV[0]), .pass(passV[0]));
    sorted_region_checker #(.DATA_W(32), .ADDR_W(7), .BASE(32), .DEPTH(4), .DESCENDING(1), .SIGNED(1), .ERR_W(9)) u1 (
        .clk(clk), .reset(reset), .start(start), .mem_addr(memAddrV[1]), .mem_rdata(memRdataV[1]),
        .exp_addr(expAddrV[1]), .exp_rdata(expRdataV[1]), .busy(busyV[1]), .done(doneV[1]),
        .err_unsorted(errU1), .err_exp(errE1), .first_bad(firstBadV[1]), .pass(passV[1]));
    sorted_region_checker #(.DATA_W(32), .ADDR_W(7), .BASE(32), .DEPTH(8), .DESCENDING(1), .SIGNED(0), .ERR_W(2)) u2 (
        .clk(clk), .reset(reset), .start(start), .mem_addr(memAddrV[2]), .mem_rdata(memRdataV[2]),
        .exp_addr(expAddrV[2]), .exp_rdata(expRdataV[2]), .busy(busyV[2]), .done(doneV[2]),
        .err_unsorted(errU2), .err_exp(errE2), .first_bad(firstBadV[2]), .pass(passV[2]));
    sorted_region_checker #(.DATA_W(32), .ADDR_W(7), .BASE(32), .DEPTH(6), .DESCENDING(0), .SIGNED(1), .ERR_W(3)) u3 (
        .clk(clk), .reset(reset), .start(start), .mem_addr(memAddrV[3]), .mem_rdata(memRdataV[3]),
        .exp_addr(expAddrV[3]), .exp_rdata(expRdataV[3]), .busy(busyV[3]), .done(doneV[3]),
        .err_unsorted(errU3), .err_exp(errE3), .first_bad(firstBadV[3]), .pass(passV[3]));

    // Any address outside an instance's window, or a non-zero ROM index with the ROM check off.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (memAddrV[k] < 7'd32 || int'(memAddrV[k]) > 31 + DEPTHS[k]) addrBad[k]++;
            if (int'(expAddrV[k]) >= DEPTHS[k] || (!EXP_ON && expAddrV[k] != 7'd0)) addrBad[k]++;
        end
    end

    // Reference: walk the window pairwise with saturating counts.
    function automatic void model(input int k, output int eU, output int eE, output int fb, output bit ps);
        int lim;
        logic [31:0] cur, prev;
        bit viol, mis, lt, gt;
        lim = (1 << ERRWS[k]) - 1;
        eU = 0;
        eE = 0;
        fb = 127;
        for (int i = 0; i < DEPTHS[k]; i++) begin
            cur  = mem[32 + i];
            viol = 1'b0;
            if (i > 0) begin
                prev = mem[31 + i];
                lt   = (SIGNS[k] != 0) ? ($signed(prev) < $signed(cur)) : (prev < cur);
                gt   = (SIGNS[k] != 0) ? ($signed(prev) > $signed(cur)) : (prev > cur);
                viol = (DESCS[k] != 0) ? lt : gt;
            end
            mis = EXP_ON && (cur != rom[i]);
            if (viol && eU < lim) eU++;
            if (mis && eE < lim) eE++;
            if ((viol || mis) && fb == 127) fb = i;
        end
        ps = (eU == 0) && (eE == 0);
    endfunction

    task automatic setDirected(input int c);
        logic [31:0] pat [8];
        case (c)
            0, 1, 4: pat = '{32'hFFFF8A4F, 32'hED9232CF, 32'hED9232CF, 32'h0000203E,
                             32'h00001000, 32'h00000100, 32'h00000010, 32'h00000001};
            2:       pat = '{32'h7FFF8A4F, 32'h0000DEAD, 32'h8000203E, 32'hFF49A03E,
                             32'h00000010, 32'h00000008, 32'h00000004, 32'h00000002};
            default: pat = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
        endcase
        for (int i = 0; i < 8; i++) begin
            mem[32 + i] = pat[i];
            rom[i]      = (c == 4) ? ~pat[i] : pat[i];
        end
        if (c == 1) mem[34] = 32'hFFFFFFFF;
    endtask

    task automatic fillRandom(input int mode);
        logic [31:0] v;
        v = $urandom;
        for (int i = 0; i < 8; i++) begin
            case (mode)
                0: mem[32 + i] = $urandom;
                1: begin mem[32 + i] = v; v = v - 32'($urandom_range(0, 3)); end
                2: mem[32 + i] = 32'($urandom_range(0, 3)) | ($urandom_range(0, 1) != 0 ? 32'h80000000 : 32'h0);
                default: begin mem[32 + i] = v; v = v + 32'($urandom_range(0, 3)); end
            endcase
            rom[i] = mem[32 + i];
            if ($urandom_range(0, 5) == 0) rom[i] = mem[32 + i] ^ (32'd1 << $urandom_range(0, 31));
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            total += 6;
            if (busyV[k] !== 1'b0 || doneV[k] !== 1'b0 || passV[k] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_flags inst%0d: busy=%b done=%b pass=%b want 0 0 0", k, busyV[k], doneV[k], passV[k]);
            end
            if (errUV[k] !== 9'd0) begin bad++; $display("[TB] FAIL reset_errU inst%0d: got %0d want 0", k, errUV[k]); end
            if (errEV[k] !== 9'd0) begin bad++; $display("[TB] FAIL reset_errE inst%0d: got %0d want 0", k, errEV[k]); end
            if (firstBadV[k] !== 7'h7F) begin bad++; $display("[TB] FAIL reset_firstBad inst%0d: got %h want 7f", k, firstBadV[k]); end
            if (memAddrV[k] !== 7'd32) begin bad++; $display("[TB] FAIL reset_memAddr inst%0d: got %0d want 32", k, memAddrV[k]); end
            if (expAddrV[k] !== 7'd0) begin bad++; $display("[TB] FAIL reset_expAddr inst%0d: got %0d want 0", k, expAddrV[k]); end
        end
    endtask

    // Directed cases 0..4 followed by randomized windows.
    task automatic test_scans();
        for (int c = 0; c < 25; c++) begin
            int eU [NI];
            int eE [NI];
            int fb [NI];
            bit ps [NI];
            int dCnt [NI];
            int dAt [NI];
            int bErr [NI];
            int aBase [NI];
            @(negedge clk);
            if (c < 5) setDirected(c);
            else fillRandom(c % 4);
            for (int k = 0; k < NI; k++) begin
                model(k, eU[k], eE[k], fb[k], ps[k]);
                dCnt[k] = 0; dAt[k] = -1; bErr[k] = 0; aBase[k] = addrBad[k];
            end
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int cyc = 0; cyc < 20; cyc++) begin
                if (cyc > 0) @(negedge clk);
                for (int k = 0; k < NI; k++) begin
                    if (doneV[k]) begin dCnt[k]++; dAt[k] = cyc; end
                    if (busyV[k] !== (cyc < DEPTHS[k])) bErr[k]++;
                end
            end
            for (int k = 0; k < NI; k++) begin
                total += 8;
                if (dCnt[k] != 1) begin bad++; $display("[TB] FAIL done_count case%0d inst%0d: got %0d want 1", c, k, dCnt[k]); end
                if (dAt[k] != DEPTHS[k]) begin bad++; $display("[TB] FAIL latency case%0d inst%0d: got %0d want %0d", c, k, dAt[k], DEPTHS[k]); end
                if (bErr[k] != 0) begin bad++; $display("[TB] FAIL busy case%0d inst%0d: %0d wrong cycles want 0", c, k, bErr[k]); end
                if (errUV[k] !== 9'(eU[k])) begin bad++; $display("[TB] FAIL errU case%0d inst%0d: got %0d want %0d", c, k, errUV[k], eU[k]); end
                if (errEV[k] !== 9'(eE[k])) begin bad++; $display("[TB] FAIL errE case%0d inst%0d: got %0d want %0d", c, k, errEV[k], eE[k]); end
                if (firstBadV[k] !== 7'(fb[k])) begin bad++; $display("[TB] FAIL firstBad case%0d inst%0d: got %0d want %0d", c, k, firstBadV[k], fb[k]); end
                if (passV[k] !== ps[k]) begin bad++; $display("[TB] FAIL pass case%0d inst%0d: got %b want %b", c, k, passV[k], ps[k]); end
                if (addrBad[k] != aBase[k]) begin bad++; $display("[TB] FAIL addr_window case%0d inst%0d: got %0d bad addrs want 0", c, k, addrBad[k] - aBase[k]); end
            end
        end
    endtask

    // Start held high for six edges: only the first edge may be accepted by any instance.
    task automatic test_back_to_back();
        int dCnt [NI];
        int dAt [NI];
        int eU, eE, fb;
        bit ps;
        @(negedge clk);
        fillRandom(1);
        for (int k = 0; k < NI; k++) begin dCnt[k] = 0; dAt[k] = -1; end
        start = 1'b1;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            if (cyc == 5) start = 1'b0;
            for (int k = 0; k < NI; k++) if (doneV[k]) begin dCnt[k]++; dAt[k] = cyc; end
        end
        for (int k = 0; k < NI; k++) begin
            model(k, eU, eE, fb, ps);
            total += 3;
            if (dCnt[k] != 1) begin bad++; $display("[TB] FAIL repulse_done_count inst%0d: got %0d want 1", k, dCnt[k]); end
            if (dAt[k] != DEPTHS[k]) begin bad++; $display("[TB] FAIL repulse_latency inst%0d: got %0d want %0d", k, dAt[k], DEPTHS[k]); end
            if (errUV[k] !== 9'(eU)) begin bad++; $display("[TB] FAIL repulse_errU inst%0d: got %0d want %0d", k, errUV[k], eU); end
        end
    endtask

    task automatic test_abort();
        int dCnt [NI];
        int eU, eE, fb;
        bit ps;
        @(negedge clk);
        setDirected(3);
        for (int k = 0; k < NI; k++) dCnt[k] = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < NI; k++) begin
            total += 4;
            if (busyV[k] !== 1'b0 || doneV[k] !== 1'b0 || passV[k] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL abort_flags inst%0d: busy=%b done=%b pass=%b want 0 0 0", k, busyV[k], doneV[k], passV[k]);
            end
            if (errUV[k] !== 9'd0 || errEV[k] !== 9'd0) begin
                bad++;
                $display("[TB] FAIL abort_counters inst%0d: got %0d/%0d want 0/0", k, errUV[k], errEV[k]);
            end
            if (firstBadV[k] !== 7'h7F) begin bad++; $display("[TB] FAIL abort_firstBad inst%0d: got %h want 7f", k, firstBadV[k]); end
            if (memAddrV[k] !== 7'd32) begin bad++; $display("[TB] FAIL abort_memAddr inst%0d: got %0d want 32", k, memAddrV[k]); end
        end
        repeat (15) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) if (doneV[k]) dCnt[k]++;
        end
        for (int k = 0; k < NI; k++) begin
            total++;
            if (dCnt[k] != 0) begin bad++; $display("[TB] FAIL abort_no_done inst%0d: got %0d pulses want 0", k, dCnt[k]); end
            dCnt[k] = 0;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) if (doneV[k]) dCnt[k]++;
        end
        for (int k = 0; k < NI; k++) begin
            model(k, eU, eE, fb, ps);
            total += 3;
            if (dCnt[k] != 1) begin bad++; $display("[TB] FAIL rerun_done_count inst%0d: got %0d want 1", k, dCnt[k]); end
            if (errUV[k] !== 9'(eU)) begin bad++; $display("[TB] FAIL rerun_errU inst%0d: got %0d want %0d", k, errUV[k], eU); end
            if (passV[k] !== ps) begin bad++; $display("[TB] FAIL rerun_pass inst%0d: got %b want %b", k, passV[k], ps); end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = 32'(i) * 32'h01010101;
            rom[i] = 32'h0;
        end
        $display("[TB] start, CHECK_EXP_EN=%0d", EXP_ON);
        test_reset();
        test_scans();
        test_back_to_back();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sorted_region_checker.md
# sorted_region_checker

Hardware self-check engine for the single-cycle MIPS sort workloads. On a start pulse it scans a parametrised window of data memory one word per cycle. For each run it counts order violations between adjacent words and mismatches against an expected-value ROM, then latches a pass/fail summary. It sits beside `single_cycle_mips`, reading the data memory through a combinational read port; the system ties `start` to `cpu.PC == END_PC`.

## Interface
- `DATA_W`, 32, word width
- `ADDR_W`, 7, word-address width of data memory and expected ROM
- `BASE`, 32, first word address of the checked window
- `DEPTH`, 96, number of words checked (2..2^ADDR_W-BASE)
- `DESCENDING`, 1, 1 = non-increasing order required, 0 = non-decreasing
- `SIGNED`, 0, 1 = two's-complement compare, 0 = unsigned
- `ERR_W`, 9, error counter width

- `clk` in 1, system clock, all state on rising edge
- `reset` in 1, synchronous, active-high
- `start` in 1, scan request, sampled only in IDLE
- `mem_addr` out ADDR_W, data-memory word address
- `mem_rdata` in DATA_W, combinational read data for `mem_addr`
- `exp_addr` out ADDR_W, expected-ROM index
- `exp_rdata` in DATA_W, combinational expected word
- `busy` out 1, scan in progress
- `done` out 1, one-cycle pulse, results final
- `err_unsorted` out ERR_W, adjacent-order violations
- `err_exp` out ERR_W, expected-value mismatches
- `first_bad` out ADDR_W, window index of first word causing any error; all-ones if none
- `pass` out 1, high when both counters are zero after a completed scan

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE → SCAN when `start`=1: counters cleared, `idx`←0, `first_bad`←all-ones, `pass`←0.
- SCAN: `mem_addr`=BASE+idx, `exp_addr`=idx. Each edge consumes one word, stores it in `prev`, and increments `idx`.
  - For idx≥1, an order violation is `prev < cur` when DESCENDING=1, or `prev > cur` when DESCENDING=0. Compares are signed when SIGNED=1. Equal words are never a violation.
  - idx=0 has no order check.
  - Exactly DEPTH-1 pairs are checked. No read outside [BASE, BASE+DEPTH-1].
  - An expected mismatch is `cur != exp_rdata`.
- One word can raise both errors; each counter increments at most 1 per cycle.
- Counters saturate at 2^ERR_W-1.
- `first_bad` latches the idx of the first cycle with any error.
- SCAN → DONE on the edge consuming idx=DEPTH-1. DONE lasts one cycle: `done`=1, `pass` updated. Next edge → IDLE.
- Results hold in IDLE until the next accepted `start`.
- `start` during SCAN or DONE is ignored. It is not queued.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, counters 0, `first_bad` all-ones, `mem_addr`=BASE, `exp_addr`=0, state IDLE.
- Start accepted at edge E0. `busy`=1 from E0 through E_DEPTH. `done` is high for the cycle between E_DEPTH and E_(DEPTH+1). `busy`=0 in DONE.
- Start-to-done latency is DEPTH edges, and throughput is 1 word/cycle. Back-to-back runs need a 1-cycle IDLE gap at minimum.
- `reset` mid-SCAN or mid-DONE: the run is aborted at that edge, all outputs return to reset values, and no `done` pulse occurs.
- Both read ports are combinational. Data must be stable within the cycle that `mem_addr` is presented.

## Configuration
- `CHECK_EXP_EN` defined: the expected-ROM comparison is active as described.
- `CHECK_EXP_EN` undefined:
  - `exp_addr` is driven 0 and `exp_rdata` is ignored.
  - `err_exp` is constant 0.
  - `pass` depends only on `err_unsorted`.
  - `first_bad` tracks order violations only.

## Test plan
- DEPTH=4, DESCENDING=1, SIGNED=0, CHECK_EXP_EN. Memory {FFFF8A4F, ED9232CF, ED9232CF, 0000203E}, ROM identical, start pulse → `done` 4 edges later, `err_unsorted`=0, `err_exp`=0, `pass`=1, `first_bad`=7F.
- Same, but memory word 2 = FFFFFFFF → `err_unsorted`=1 (pair 1–2), `err_exp`=1, `first_bad`=2, `pass`=0.
- SIGNED=1, DESCENDING=1, memory {7FFF8A4F, 0000DEAD, 8000203E, FF49A03E} → `err_unsorted`=1 (8000203E < FF49A03E signed), `first_bad`=3. With SIGNED=0 the same data gives `err_unsorted`=2 (0000DEAD<8000203E, 8000203E<FF49A03E) and `first_bad`=2.
- ERR_W=2, DEPTH=8, DESCENDING=1, strictly ascending memory 0..7 → `err_unsorted` saturates at 3. Memory address never exceeds BASE+7.
- Reset asserted 2 cycles into SCAN → no `done` pulse, counters 0, `first_bad`=7F. A new start then completes normally.
- Start re-pulsed every cycle during SCAN → exactly one `done` per accepted start. Without CHECK_EXP_EN, an all-mismatched ROM still gives `err_exp`=0 and `pass`=1.
